// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - bundle field widths (PC, instruction, exception cause)
//   - ADEF cause code used for a misaligned fetch PC
//   - fetch FSM state encoding
package fetch_unit_pkg;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int CAUSE_W = 7;

    localparam logic [CAUSE_W-1:0] ADEF_CAUSE_DEF = 7'h08;

    typedef enum logic [2:0] {
        S_REQ    = 3'd0,  // issue the icache request
        S_WAIT   = 3'd1,  // request accepted, waiting for data
        S_HOLD   = 3'd2,  // bundle captured, waiting for the buffer
        S_CANCEL = 3'd3,  // swallow the response of a flushed request
        S_EXC    = 3'd4   // halted on a fetch exception until flush
    } fetch_state_e;

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC / slot-valid logic for one aligned fetch pair.
//   fetch_pc            : PC of slot 1 (slot 2 is fetch_pc+4)
//   taken[0]/taken[1]   : predicted-taken for slot 1 / slot 2
//   target1/target2     : predicted targets
//   next_pc             : PC of the following fetch
//   inst_valid2         : slot 2 is part of this fetch
//   pred_taken          : taken bits, slot 2 masked when it is not valid
//   pred_addr1/2        : predicted next PC per slot
module fetch_npc
    import fetch_unit_pkg::*;
(
    input  logic [PC_W-1:0] fetch_pc,
    input  logic [1:0]      taken,
    input  logic [PC_W-1:0] target1,
    input  logic [PC_W-1:0] target2,
    output logic [PC_W-1:0] next_pc,
    output logic            inst_valid2,
    output logic [1:0]      pred_taken,
    output logic [PC_W-1:0] pred_addr1,
    output logic [PC_W-1:0] pred_addr2
);

    always_comb begin
        // Slot 2 only exists when slot 1 starts an 8-byte pair and does not branch away.
        inst_valid2 = !fetch_pc[2] && !taken[0];
        pred_taken  = {taken[1] && inst_valid2, taken[0]};
        pred_addr1  = taken[0]      ? target1 : fetch_pc + 32'd4;
        pred_addr2  = pred_taken[1] ? target2 : fetch_pc + 32'd8;

        if (taken[0])
            next_pc = target1;
        else if (pred_taken[1])
            next_pc = target2;
        else
            next_pc = {fetch_pc[PC_W-1:3], 3'b000} + 32'd8;  // wraps mod 2^32
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the instruction buffer.
// Owns the fetch PC, issues one aligned dual-instruction icache request at a
// time, attaches branch prediction and fetch-exception info, and pushes the
// pair to the buffer as a single bundle (icache_valid_out).
//   clk, rst (async, active low)  flush/new_pc: redirect   stall_in: buffer full
//   bpu_*      : predictor lookup on bpu_pc (combinational response)
//   icache_*   : request/accept/response handshake
//   pc*/inst*/inst_valid*/pred_*/pc_is_exception_out*/pc_exception_cause_out*:
//                bundle fields, stable while in HOLD
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC   = 32'h8000_0000,
    parameter logic [CAUSE_W-1:0] ADEF_CAUSE = ADEF_CAUSE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [PC_W-1:0]    new_pc,
    input  logic               stall_in,
    output logic [PC_W-1:0]    bpu_pc,
    input  logic [1:0]         bpu_taken,
    input  logic [PC_W-1:0]    bpu_target1,
    input  logic [PC_W-1:0]    bpu_target2,
    output logic               icache_req,
    output logic [PC_W-1:0]    icache_addr,
    input  logic               icache_addr_ok,
    input  logic               icache_data_ok,
    input  logic [INST_W-1:0]  icache_rdata1,
    input  logic [INST_W-1:0]  icache_rdata2,
    output logic               icache_valid_out,
    output logic [PC_W-1:0]    pc1,
    output logic [PC_W-1:0]    pc2,
    output logic [INST_W-1:0]  inst1,
    output logic [INST_W-1:0]  inst2,
    output logic               inst_valid1,
    output logic               inst_valid2,
    output logic [1:0]         pred_taken,
    output logic [PC_W-1:0]    pred_addr1,
    output logic [PC_W-1:0]    pred_addr2,
    output logic               pc_is_exception_out1,
    output logic               pc_is_exception_out2,
    output logic [CAUSE_W-1:0] pc_exception_cause_out1,
    output logic [CAUSE_W-1:0] pc_exception_cause_out2
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] next_pc_q;
    logic            exc_q;
    logic            misaligned;

    logic [PC_W-1:0] npc_next, npc_pa1, npc_pa2;
    logic            npc_v2;
    logic [1:0]      npc_ptk;

    fetch_npc u_npc (
        .fetch_pc    (fetch_pc),
        .taken       (bpu_taken),
        .target1     (bpu_target1),
        .target2     (bpu_target2),
        .next_pc     (npc_next),
        .inst_valid2 (npc_v2),
        .pred_taken  (npc_ptk),
        .pred_addr1  (npc_pa1),
        .pred_addr2  (npc_pa2)
    );

    assign bpu_pc           = fetch_pc;
    assign misaligned       = fetch_pc[1:0] != 2'b00;
    // Gated by rst so nothing is requested while reset is held.
    assign icache_req       = rst && (state_q == S_REQ) && !misaligned;
    assign icache_addr      = icache_req ? fetch_pc : '0;
    assign icache_valid_out = (state_q == S_HOLD) && !stall_in && !flush;

    // Slot 2 of a pair whose slot 1 is aligned is aligned too, so it never faults.
    assign pc_is_exception_out2    = 1'b0;
    assign pc_exception_cause_out2 = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_REQ;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (flush)
                    state_d = (icache_req && icache_addr_ok) ? S_CANCEL : S_REQ;
                else if (misaligned)
                    state_d = S_HOLD;
                else if (icache_addr_ok)
                    state_d = S_WAIT;
            end
            // A response arriving together with the flush already retires the
            // request, so there is nothing left to cancel.
            S_WAIT: begin
                if (flush)
                    state_d = icache_data_ok ? S_REQ : S_CANCEL;
                else if (icache_data_ok)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (flush)
                    state_d = S_REQ;
                else if (!stall_in)
                    state_d = exc_q ? S_EXC : S_REQ;
            end
            S_CANCEL: begin
                if (icache_data_ok)
                    state_d = S_REQ;
            end
            S_EXC: begin
                if (flush)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc                <= RESET_PC;
            next_pc_q               <= '0;
            exc_q                   <= 1'b0;
            pc1                     <= '0;
            pc2                     <= '0;
            inst1                   <= '0;
            inst2                   <= '0;
            inst_valid1             <= 1'b0;
            inst_valid2             <= 1'b0;
            pred_taken              <= '0;
            pred_addr1              <= '0;
            pred_addr2              <= '0;
            pc_is_exception_out1    <= 1'b0;
            pc_exception_cause_out1 <= '0;
        end else if (flush) begin
            fetch_pc <= new_pc;
            exc_q    <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (misaligned) begin
                        pc1                     <= fetch_pc;
                        pc2                     <= fetch_pc + 32'd4;
                        inst1                   <= '0;
                        inst2                   <= '0;
                        inst_valid1             <= 1'b1;
                        inst_valid2             <= 1'b0;
                        pred_taken              <= '0;
                        pred_addr1              <= fetch_pc + 32'd4;
                        pred_addr2              <= fetch_pc + 32'd8;
                        pc_is_exception_out1    <= 1'b1;
                        pc_exception_cause_out1 <= ADEF_CAUSE;
                        exc_q                   <= 1'b1;
                    end else if (icache_addr_ok) begin
                        // Prediction is taken from the accept cycle; bpu_pc == fetch_pc.
                        pc1                     <= fetch_pc;
                        pc2                     <= fetch_pc + 32'd4;
                        inst_valid1             <= 1'b1;
                        inst_valid2             <= npc_v2;
                        pred_taken              <= npc_ptk;
                        pred_addr1              <= npc_pa1;
                        pred_addr2              <= npc_pa2;
                        pc_is_exception_out1    <= 1'b0;
                        pc_exception_cause_out1 <= '0;
                        next_pc_q               <= npc_next;
                        exc_q                   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (icache_data_ok) begin
                        inst1 <= icache_rdata1;
                        inst2 <= icache_rdata2;
                    end
                end
                S_HOLD: begin
                    if (!stall_in)
                        fetch_pc <= next_pc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        stall_in = 1'b0;
    logic [31:0] bpu_pc;
    logic [1:0]  bpu_taken = '0;
    logic [31:0] bpu_target1 = '0, bpu_target2 = '0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok = 1'b0, icache_data_ok = 1'b0;
    logic [31:0] icache_rdata1 = '0, icache_rdata2 = '0;
    logic        icache_valid_out;
    logic [31:0] pc1, pc2, inst1, inst2, pred_addr1, pred_addr2;
    logic        inst_valid1, inst_valid2;
    logic [1:0]  pred_taken;
    logic        pc_is_exception_out1, pc_is_exception_out2;
    logic [6:0]  pc_exception_cause_out1, pc_exception_cause_out2;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h8000_0000), .ADEF_CAUSE(7'h08)) dut (
        .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall_in(stall_in),
        .bpu_pc(bpu_pc), .bpu_taken(bpu_taken), .bpu_target1(bpu_target1),
        .bpu_target2(bpu_target2), .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
        .icache_rdata1(icache_rdata1), .icache_rdata2(icache_rdata2),
        .icache_valid_out(icache_valid_out), .pc1(pc1), .pc2(pc2), .inst1(inst1),
        .inst2(inst2), .inst_valid1(inst_valid1), .inst_valid2(inst_valid2),
        .pred_taken(pred_taken), .pred_addr1(pred_addr1), .pred_addr2(pred_addr2),
        .pc_is_exception_out1(pc_is_exception_out1),
        .pc_is_exception_out2(pc_is_exception_out2),
        .pc_exception_cause_out1(pc_exception_cause_out1),
        .pc_exception_cause_out2(pc_exception_cause_out2)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=no summary expected=finish before timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the pushed bundle must contain for a fetch at pc.
    task automatic chk_bundle(input string tag, input logic [31:0] pc, input logic [1:0] tk,
                              input logic [31:0] t1, input logic [31:0] t2,
                              input logic [31:0] r1, input logic [31:0] r2, input bit exc);
        bit          v2;
        logic [1:0]  ptk;
        v2  = !exc && ((pc % 8) == 0) && !tk[0];
        ptk = exc ? 2'b00 : {tk[1] && v2, tk[0]};
        chk({tag, ".pc1"}, pc1, pc);
        chk({tag, ".pc2"}, pc2, pc + 4);
        chk({tag, ".inst1"}, inst1, exc ? 32'h0 : r1);
        if (v2) chk({tag, ".inst2"}, inst2, r2);
        chk({tag, ".valid1"}, {31'b0, inst_valid1}, 32'd1);
        chk({tag, ".valid2"}, {31'b0, inst_valid2}, {31'b0, v2});
        chk({tag, ".pred_taken"}, {30'b0, pred_taken}, {30'b0, ptk});
        chk({tag, ".pred_addr1"}, pred_addr1, ptk[0] ? t1 : pc + 4);
        chk({tag, ".pred_addr2"}, pred_addr2, ptk[1] ? t2 : pc + 8);
        chk({tag, ".exc1"}, {31'b0, pc_is_exception_out1}, {31'b0, exc});
        chk({tag, ".cause1"}, {25'b0, pc_exception_cause_out1}, exc ? 32'h08 : 32'h0);
        chk({tag, ".exc2"}, {31'b0, pc_is_exception_out2}, 32'd0);
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] tk,
                                             input logic [31:0] t1, input logic [31:0] t2);
        if (tk[0]) return t1;
        if (((pc % 8) == 0) && tk[1]) return t2;
        return (pc / 8) * 8 + 8;
    endfunction

    // Full fetch starting at a negedge with the DUT in REQ at pc.
    task automatic do_fetch(input string tag, input logic [31:0] pc, input logic [1:0] tk,
                            input logic [31:0] t1, input logic [31:0] t2,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input int alat, input int dlat, input int nstall,
                            output logic [31:0] npc);
        npc = ref_next(pc, tk, t1, t2);
        bpu_taken = tk; bpu_target1 = t1; bpu_target2 = t2;
        for (int i = 0; i < alat; i++) begin
            #1 chk({tag, ".req_pending"}, {31'b0, icache_req}, 32'd1);
            @(negedge clk);
        end
        icache_addr_ok = 1'b1;
        #1;
        chk({tag, ".req"}, {31'b0, icache_req}, 32'd1);
        chk({tag, ".req_addr"}, icache_addr, pc);
        chk({tag, ".bpu_pc"}, bpu_pc, pc);
        @(negedge clk);
        icache_addr_ok = 1'b0;
        // Predictor output moves on; the bundle must keep the accept-cycle values.
        bpu_taken = 2'($urandom); bpu_target1 = $urandom; bpu_target2 = $urandom;
        #1 chk({tag, ".req_dropped"}, {31'b0, icache_req}, 32'd0);
        for (int i = 0; i < dlat; i++) @(negedge clk);
        icache_data_ok = 1'b1; icache_rdata1 = r1; icache_rdata2 = r2;
        #1 chk({tag, ".no_push_wait"}, {31'b0, icache_valid_out}, 32'd0);
        @(negedge clk);
        icache_data_ok = 1'b0; icache_rdata1 = $urandom; icache_rdata2 = $urandom;
        for (int i = 0; i < nstall; i++) begin
            stall_in = 1'b1;
            #1;
            chk({tag, ".stall_no_push"}, {31'b0, icache_valid_out}, 32'd0);
            chk({tag, ".stall_req"}, {31'b0, icache_req}, 32'd0);
            if (i == nstall - 1) chk_bundle({tag, ".stall"}, pc, tk, t1, t2, r1, r2, 1'b0);
            @(negedge clk);
        end
        stall_in = 1'b0;
        #1;
        chk({tag, ".push"}, {31'b0, icache_valid_out}, 32'd1);
        chk_bundle(tag, pc, tk, t1, t2, r1, r2, 1'b0);
        @(negedge clk);
        #1;
        chk({tag, ".single_push"}, {31'b0, icache_valid_out}, 32'd0);
        chk({tag, ".next_pc"}, bpu_pc, npc);
        chk({tag, ".next_req"}, {31'b0, icache_req}, {31'b0, npc[1:0] == 2'b00});
    endtask

    // Redirect while in REQ with no acceptance (or from HOLD/EXC).
    task automatic flush_to(input logic [31:0] target);
        flush = 1'b1; new_pc = target;
        #1 chk("flush_no_push", {31'b0, icache_valid_out}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_pc", bpu_pc, target);
    endtask

    initial begin
        logic [31:0] npc, pc;
        logic [1:0]  tk;
        logic [31:0] t1, t2;

        // Reset.
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst.req", {31'b0, icache_req}, 32'd0);
        chk("rst.addr", icache_addr, 32'd0);
        chk("rst.valid_out", {31'b0, icache_valid_out}, 32'd0);
        chk("rst.bpu_pc", bpu_pc, 32'h8000_0000);
        chk("rst.pc1", pc1, 32'd0);
        chk("rst.valid1", {31'b0, inst_valid1}, 32'd0);
        chk("rst.pred_taken", {30'b0, pred_taken}, 32'd0);
        chk("rst.exc1", {31'b0, pc_is_exception_out1}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("boot.req", {31'b0, icache_req}, 32'd1);
        chk("boot.addr", icache_addr, 32'h8000_0000);

        // Plain pair, addr_ok and data_ok one cycle apart.
        do_fetch("pair", 32'h8000_0000, 2'b00, 32'h0, 32'h0, 32'h11, 32'h22, 0, 0, 0, npc);
        // Odd-word start: slot 2 invalid.
        flush_to(32'h8000_0004);
        do_fetch("odd", 32'h8000_0004, 2'b00, 32'h0, 32'h0, 32'h33, 32'h44, 1, 0, 0, npc);
        // Slot 1 predicted taken.
        do_fetch("taken1", 32'h8000_0008, 2'b01, 32'h8000_1000, 32'h8000_2000,
                 32'h55, 32'h66, 0, 1, 0, npc);
        // Buffer stall.
        do_fetch("stall", 32'h8000_1000, 2'b00, 32'h0, 32'h0, 32'h77, 32'h88, 0, 0, 5, npc);

        // Flush while waiting for data: response must be swallowed.
        bpu_taken = 2'b00;
        icache_addr_ok = 1'b1;
        #1 chk("wflush.req_addr", icache_addr, 32'h8000_1008);
        @(negedge clk);
        icache_addr_ok = 1'b0;
        flush = 1'b1; new_pc = 32'h1c00_0000;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("cancel.req", {31'b0, icache_req}, 32'd0);
        chk("cancel.pc", bpu_pc, 32'h1c00_0000);
        @(negedge clk); @(negedge clk);
        icache_data_ok = 1'b1; icache_rdata1 = 32'hdead; icache_rdata2 = 32'hbeef;
        #1 chk("cancel.no_push", {31'b0, icache_valid_out}, 32'd0);
        @(negedge clk);
        icache_data_ok = 1'b0;
        #1;
        chk("cancel.no_push2", {31'b0, icache_valid_out}, 32'd0);
        chk("cancel.req_after", {31'b0, icache_req}, 32'd1);
        chk("cancel.addr_after", icache_addr, 32'h1c00_0000);
        // Slot 2 predicted taken.
        do_fetch("taken2", 32'h1c00_0000, 2'b10, 32'h1c00_0800, 32'h1c00_0400,
                 32'h99, 32'haa, 2, 2, 1, npc);

        // Misaligned redirect -> exception bundle, then idle until flush.
        flush_to(32'h8000_0002);
        #1;
        chk("exc.no_req", {31'b0, icache_req}, 32'd0);
        chk("exc.no_push_req", {31'b0, icache_valid_out}, 32'd0);
        @(negedge clk);
        #1;
        chk("exc.push", {31'b0, icache_valid_out}, 32'd1);
        chk_bundle("exc", 32'h8000_0002, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("exc.idle_req", {31'b0, icache_req}, 32'd0);
            chk("exc.idle_push", {31'b0, icache_valid_out}, 32'd0);
        end
        flush_to(32'hffff_fff8);
        #1 chk("exc.resume", {31'b0, icache_req}, 32'd1);

        // Sequential PC wraps to zero.
        do_fetch("wrap", 32'hffff_fff8, 2'b00, 32'h0, 32'h0, 32'h1, 32'h2, 0, 0, 0, npc);
        chk("wrap.next", npc, 32'h0);

        // Random fetch stream with occasional redirects.
        pc = npc;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                pc = $urandom & 32'hffff_fffc;
                flush_to(pc);
            end
            tk = 2'($urandom_range(0, 3));
            t1 = $urandom & 32'hffff_fffc;
            t2 = $urandom & 32'hffff_fffc;
            do_fetch("rand", pc, tk, t1, t2, $urandom, $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), npc);
            pc = npc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
